ctrl_pipe_n: RTL and testbench

CTRL_PIPE_N -- requirements
Module: ctrl_pipe_n

---
 rtl/ctrl_pipe_pkg.sv | 11 +
 rtl/ctrl_stage.sv | 26 ++
 rtl/ctrl_pipe_n.sv | 54 +++++
 tb/tb_ctrl_pipe_n.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared defaults and stage types for the post-decode control pipeline.
package ctrl_pipe_pkg;
    localparam int DEF_CW   = 8;
    localparam int DEF_NSTG = 3;
    localparam int DEF_MLAT = 4;
    typedef enum logic [1:0] {SEL_HOLD, SEL_LOAD, SEL_BUBBLE} stageSel_t;
    typedef struct packed {
        logic              valid;
        logic [DEF_CW-1:0] word;
    } stageRec_t;
endpackage

// File: rtl/ctrl_stage.sv
// ctrl_stage: one pipeline register for a control word, with hold/load/bubble select.
module ctrl_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  stageSel_t     sel,
    input  logic [CW-1:0] dCtrl,
    input  logic          dValid,
    output logic [CW-1:0] qCtrl,
    output logic          qValid
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            qCtrl  <= '0;
            qValid <= 1'b0;
        end else if (sel == SEL_LOAD) begin
            qCtrl  <= dCtrl;
            qValid <= dValid;
        end else if (sel == SEL_BUBBLE) begin
            qCtrl  <= '0;
            qValid <= 1'b0;
        end
endmodule

// File: rtl/ctrl_pipe_n.sv
// ctrl_pipe_n: NSTG-deep control-word pipeline after decode; multi-cycle ops hold E for MLAT cycles.
module ctrl_pipe_n
    import ctrl_pipe_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int NSTG = DEF_NSTG,
    parameter int MLAT = DEF_MLAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW-1:0]      ctrl_d,
    input  logic               valid_d,
    input  logic               multi_d,
    input  logic               stall_d,
    input  logic               flush_e,
    output logic [NSTG*CW-1:0] ctrl_o,
    output logic [NSTG-1:0]    valid_o,
    output logic               busy_o,
    output logic               stall_o
);
    localparam int CNTW = $clog2(MLAT) + 1;
    logic [CNTW-1:0] cnt;
    logic            loadE;
    stageSel_t       eSel, mSel;
    assign busy_o  = |cnt;
    assign stall_o = busy_o;
    // Stall beats a multi op: nothing is accepted, so no counter start either.
    always_comb begin
        loadE = ~busy_o & valid_d & ~stall_d & ~flush_e;
        eSel  = busy_o ? SEL_HOLD : (loadE ? SEL_LOAD : SEL_BUBBLE);
        mSel  = busy_o ? SEL_BUBBLE : SEL_LOAD;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (loadE && multi_d)
            cnt <= CNTW'(MLAT - 1);
        else if (busy_o)
            cnt <= cnt - 1'b1;
    for (genvar i = 0; i < NSTG; i++) begin : g_stg
        if (i == 0) begin : g_e
            ctrl_stage #(.CW(CW)) u_stage (
                .clk(clk), .reset(reset), .sel(eSel), .dCtrl(ctrl_d), .dValid(1'b1),
                .qCtrl(ctrl_o[i*CW +: CW]), .qValid(valid_o[i])
            );
        end else begin : g_n
            ctrl_stage #(.CW(CW)) u_stage (
                .clk(clk), .reset(reset), .sel((i == 1) ? mSel : SEL_LOAD),
                .dCtrl(ctrl_o[(i-1)*CW +: CW]), .dValid(valid_o[i-1]),
                .qCtrl(ctrl_o[i*CW +: CW]), .qValid(valid_o[i])
            );
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_n.sv
// tb_ctrl_pipe_n: directed table, reset corner and random traffic for three ctrl_pipe_n configurations.
module tb_ctrl_pipe_n;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] ctrl_d = '0;
    logic valid_d = 1'b0, multi_d = 1'b0, stall_d = 1'b0, flush_e = 1'b0;
    logic [23:0] c0, c1;
    logic [39:0] c2;
    logic [2:0] v0, v1;
    logic [4:0] v2;
    logic b0, b1, b2, s0, s1, s2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_n #(.CW(8), .NSTG(3), .MLAT(4)) dut0 (.clk(clk), .reset(rst_n), .ctrl_d(ctrl_d),
        .valid_d(valid_d), .multi_d(multi_d), .stall_d(stall_d), .flush_e(flush_e),
        .ctrl_o(c0), .valid_o(v0), .busy_o(b0), .stall_o(s0));
    ctrl_pipe_n #(.CW(8), .NSTG(3), .MLAT(1)) dut1 (.clk(clk), .reset(rst_n), .ctrl_d(ctrl_d),
        .valid_d(valid_d), .multi_d(multi_d), .stall_d(stall_d), .flush_e(flush_e),
        .ctrl_o(c1), .valid_o(v1), .busy_o(b1), .stall_o(s1));
    ctrl_pipe_n #(.CW(8), .NSTG(5), .MLAT(4)) dut2 (.clk(clk), .reset(rst_n), .ctrl_d(ctrl_d),
        .valid_d(valid_d), .multi_d(multi_d), .stall_d(stall_d), .flush_e(flush_e),
        .ctrl_o(c2), .valid_o(v2), .busy_o(b2), .stall_o(s2));

    function automatic int ns(int c); return (c == 2) ? 5 : 3; endfunction
    function automatic int ml(int c); return (c == 1) ? 1 : 4; endfunction

    // Reference: stage contents plus the edge at which the current E occupant arrived.
    logic [7:0] mc [3][5];
    logic       mv [3][5];
    logic       eMul [3];
    int         enter [3];
    int         n;

    function automatic logic mBusy(int c);
        return eMul[c] && (n - enter[c] < ml(c));
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 5; i++) begin mc[c][i] = '0; mv[c][i] = 1'b0; end
            eMul[c] = 1'b0; enter[c] = 0;
        end
        n = 0;
    endtask

    task automatic modelEdge();
        for (int c = 0; c < 3; c++) begin
            logic hold;
            hold = mBusy(c);
            for (int i = ns(c) - 1; i >= 2; i--) begin mc[c][i] = mc[c][i-1]; mv[c][i] = mv[c][i-1]; end
            mc[c][1] = hold ? 8'h00 : mc[c][0];
            mv[c][1] = hold ? 1'b0 : mv[c][0];
            if (!hold) begin
                if (flush_e || stall_d || !valid_d) begin
                    mc[c][0] = '0; mv[c][0] = 1'b0; eMul[c] = 1'b0;
                end else begin
                    mc[c][0] = ctrl_d; mv[c][0] = 1'b1; eMul[c] = multi_d; enter[c] = n;
                end
            end
        end
        n++;
    endtask

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
        end
    endtask

    task automatic compareAll();
        for (int c = 0; c < 3; c++) begin
            logic [39:0] ec, ac;
            logic [4:0]  ev, av;
            logic        ab, as;
            ec = '0; ev = '0;
            for (int i = 0; i < ns(c); i++) begin ec[i*8 +: 8] = mc[c][i]; ev[i] = mv[c][i]; end
            ac = (c == 0) ? {16'h0, c0} : (c == 1) ? {16'h0, c1} : c2;
            av = (c == 0) ? {2'b0, v0} : (c == 1) ? {2'b0, v1} : v2;
            ab = (c == 0) ? b0 : (c == 1) ? b1 : b2;
            as = (c == 0) ? s0 : (c == 1) ? s1 : s2;
            chk($sformatf("ctrl_o cfg%0d", c), 64'(ac), 64'(ec));
            chk($sformatf("valid_o cfg%0d", c), 64'(av), 64'(ev));
            chk($sformatf("busy_o cfg%0d", c), 64'(ab), 64'(mBusy(c)));
            chk($sformatf("stall_o cfg%0d", c), 64'(as), 64'(mBusy(c)));
        end
    endtask

    task automatic step(logic [7:0] c, logic v, logic m, logic s, logic f);
        @(negedge clk);
        ctrl_d = c; valid_d = v; multi_d = m; stall_d = s; flush_e = f;
        @(posedge clk);
        modelEdge();
        #1 compareAll();
    endtask

    typedef struct {
        logic [7:0] c;
        logic       v, m, s, f;
        logic [7:0] eC, mC, wC;
        logic [2:0] vo;
        logic       bz;
    } vec_t;
    vec_t tbl [13];

    initial begin
        tbl[0]  = '{8'hA5, 1, 0, 0, 0, 8'hA5, 8'h00, 8'h00, 3'b001, 0};
        tbl[1]  = '{8'h00, 0, 0, 0, 0, 8'h00, 8'hA5, 8'h00, 3'b010, 0};
        tbl[2]  = '{8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5, 3'b100, 0};
        tbl[3]  = '{8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0};
        tbl[4]  = '{8'h3C, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0};
        tbl[5]  = '{8'h3C, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0};
        tbl[6]  = '{8'h81, 1, 1, 0, 0, 8'h81, 8'h00, 8'h00, 3'b001, 1};
        tbl[7]  = '{8'h42, 1, 0, 0, 0, 8'h81, 8'h00, 8'h00, 3'b001, 1};
        tbl[8]  = '{8'h42, 1, 0, 0, 1, 8'h81, 8'h00, 8'h00, 3'b001, 1};
        tbl[9]  = '{8'h42, 1, 0, 0, 0, 8'h81, 8'h00, 8'h00, 3'b001, 0};
        tbl[10] = '{8'h42, 1, 0, 0, 0, 8'h42, 8'h81, 8'h00, 3'b011, 0};
        tbl[11] = '{8'h00, 0, 0, 0, 0, 8'h00, 8'h42, 8'h81, 3'b110, 0};
        tbl[12] = '{8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h42, 3'b100, 0};

        modelReset();
        repeat (2) @(negedge clk);
        #1 compareAll();
        chk("reset valid", 64'(v0), 64'h0);
        rst_n = 1'b1;

        for (int r = 0; r < 13; r++) begin
            step(tbl[r].c, tbl[r].v, tbl[r].m, tbl[r].s, tbl[r].f);
            chk($sformatf("tbl%0d E", r), 64'(c0[7:0]), 64'(tbl[r].eC));
            chk($sformatf("tbl%0d M", r), 64'(c0[15:8]), 64'(tbl[r].mC));
            chk($sformatf("tbl%0d W", r), 64'(c0[23:16]), 64'(tbl[r].wC));
            chk($sformatf("tbl%0d valid", r), 64'(v0), 64'(tbl[r].vo));
            chk($sformatf("tbl%0d busy", r), 64'(b0), 64'(tbl[r].bz));
            chk($sformatf("tbl%0d mlat1 busy", r), 64'(b1), 64'h0);
        end

        // Deep pipe latency: word accepted at edge t is in stage 4 at edge t+4.
        step(8'hD7, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(8'h00, 0, 0, 0, 0);
        chk("nstg5 stage4", 64'(c2[39:32]), 64'hD7);
        chk("nstg5 valid4", 64'(v2), 64'h10);

        // Reset in the middle of a multi op clears everything without a clock.
        step(8'h81, 1, 1, 0, 0);
        step(8'h00, 0, 0, 0, 0);
        chk("pre-reset busy", 64'(b0), 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 modelReset();
        compareAll();
        chk("async rst valid", 64'(v0), 64'h0);
        chk("async rst busy", 64'(b0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h5A, 1, 0, 0, 0);
        chk("post-reset load", 64'(c0[7:0]), 64'h5A);

        for (int k = 0; k < 400; k++)
            step(8'($urandom), ($urandom_range(3) != 0), ($urandom_range(9) < 3),
                 ($urandom_range(19) < 3), ($urandom_range(9) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
